// File: rtl/medidor_pwm_pkg.sv
// Shared constants for the servo PWM generator / measurer pair.
// Holds default pulse widths, period, tolerance, the FSM state encoding
// and the midpoint helper used to build the decode thresholds.
package medidor_pwm_pkg;

    localparam int unsigned LARG_W = 17;   // width of the high-pulse counter
    localparam int unsigned TMO_W  = 21;   // width of the timeout counter

    localparam int unsigned CONF_PERIODO_PAD = 1000000;  // 20 ms at 50 MHz
    localparam int unsigned LARGURA_000_PAD  = 35000;
    localparam int unsigned LARGURA_001_PAD  = 45700;
    localparam int unsigned LARGURA_010_PAD  = 56450;
    localparam int unsigned LARGURA_011_PAD  = 67150;
    localparam int unsigned LARGURA_100_PAD  = 77850;
    localparam int unsigned LARGURA_101_PAD  = 88550;
    localparam int unsigned LARGURA_110_PAD  = 99300;
    localparam int unsigned LARGURA_111_PAD  = 110000;
    localparam int unsigned TOLERANCIA_PAD   = 5000;

    typedef enum logic [1:0] {
        INICIAL       = 2'd0,
        ESPERA_SUBIDA = 2'd1,
        MEDE_ALTO     = 2'd2,
        CLASSIFICA    = 2'd3
    } estado_t;

    // Decode threshold between two adjacent nominal widths; odd sums round down.
    function automatic int unsigned limiar_medio(input int unsigned a, input int unsigned b);
        return (a + b) / 2;
    endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// Two-flop synchronizer for the asynchronous PWM line followed by a
// registered edge detector. Rise/fall strobes appear 3 clocks after the
// input changes; nivel_o is the synchronized level aligned with them.
module sincronizador_borda (
    input  logic clock,
    input  logic reset,
    input  logic assincrono_i,
    output logic nivel_o,
    output logic subida_o,
    output logic descida_o
);

    logic meta_q;
    logic sinc_q;
    logic nivel_q;
    logic subida_q;
    logic descida_q;

    // Synchronizer chain; left unreset so a reset never fakes an edge on a high line.
    always_ff @(posedge clock) begin
        meta_q  <= assincrono_i;
        sinc_q  <= meta_q;
        nivel_q <= sinc_q;
    end

    // One-cycle edge strobes on the synchronized signal.
    always_ff @(posedge clock) begin
        if (reset) begin
            subida_q  <= 1'b0;
            descida_q <= 1'b0;
        end else begin
            subida_q  <= sinc_q & ~nivel_q;
            descida_q <= ~sinc_q & nivel_q;
        end
    end

    assign nivel_o   = nivel_q;
    assign subida_o  = subida_q;
    assign descida_o = descida_q;

endmodule

// File: rtl/medidor_pwm_servo.sv
// Servo PWM receiver: measures the high width of each pulse, decodes it to
// a 3-bit position code and flags out-of-range pulses and loss of signal.
// Optional build macro MEDIDOR_FILTRO_CONFIRMACAO_EN: a new code is only
// accepted after two consecutive in-range pulses decode to the same value.
module medidor_pwm_servo
    import medidor_pwm_pkg::*;
#(
    parameter int unsigned CONF_PERIODO = CONF_PERIODO_PAD,
    parameter int unsigned LARGURA_000  = LARGURA_000_PAD,
    parameter int unsigned LARGURA_001  = LARGURA_001_PAD,
    parameter int unsigned LARGURA_010  = LARGURA_010_PAD,
    parameter int unsigned LARGURA_011  = LARGURA_011_PAD,
    parameter int unsigned LARGURA_100  = LARGURA_100_PAD,
    parameter int unsigned LARGURA_101  = LARGURA_101_PAD,
    parameter int unsigned LARGURA_110  = LARGURA_110_PAD,
    parameter int unsigned LARGURA_111  = LARGURA_111_PAD,
    parameter int unsigned TOLERANCIA   = TOLERANCIA_PAD,
    parameter int unsigned TIMEOUT      = 2 * CONF_PERIODO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [2:0]        posicao,
    output logic              posicao_valida,
    output logic [LARG_W-1:0] largura_medida,
    output logic              erro,
    output logic              sem_sinal,
    output logic [1:0]        db_estado
);

    // Decode thresholds: a width at or above LIM_xxx decodes to code xxx or higher.
    localparam logic [LARG_W-1:0] LIM_001 = LARG_W'(limiar_medio(LARGURA_000, LARGURA_001));
    localparam logic [LARG_W-1:0] LIM_010 = LARG_W'(limiar_medio(LARGURA_001, LARGURA_010));
    localparam logic [LARG_W-1:0] LIM_011 = LARG_W'(limiar_medio(LARGURA_010, LARGURA_011));
    localparam logic [LARG_W-1:0] LIM_100 = LARG_W'(limiar_medio(LARGURA_011, LARGURA_100));
    localparam logic [LARG_W-1:0] LIM_101 = LARG_W'(limiar_medio(LARGURA_100, LARGURA_101));
    localparam logic [LARG_W-1:0] LIM_110 = LARG_W'(limiar_medio(LARGURA_101, LARGURA_110));
    localparam logic [LARG_W-1:0] LIM_111 = LARG_W'(limiar_medio(LARGURA_110, LARGURA_111));

    localparam logic [LARG_W-1:0] MIN_OK    = LARG_W'(LARGURA_000 - TOLERANCIA);
    localparam logic [LARG_W-1:0] MAX_OK    = LARG_W'(LARGURA_111 + TOLERANCIA);
    localparam logic [LARG_W-1:0] CNT_MAX   = '1;
    localparam logic [TMO_W-1:0]  TIMEOUT_V = TMO_W'(TIMEOUT);

    // Map a measured width to the nearest nominal code.
    function automatic logic [2:0] decodifica(input logic [LARG_W-1:0] w);
        if (w >= LIM_111)      return 3'd7;
        else if (w >= LIM_110) return 3'd6;
        else if (w >= LIM_101) return 3'd5;
        else if (w >= LIM_100) return 3'd4;
        else if (w >= LIM_011) return 3'd3;
        else if (w >= LIM_010) return 3'd2;
        else if (w >= LIM_001) return 3'd1;
        else                   return 3'd0;
    endfunction

    logic nivel;
    logic subida;
    logic descida;

    sincronizador_borda u_sinc (
        .clock        (clock),
        .reset        (reset),
        .assincrono_i (pwm_in),
        .nivel_o      (nivel),
        .subida_o     (subida),
        .descida_o    (descida)
    );

    estado_t           estado_q,    estado_d;
    logic [LARG_W-1:0] cnt_alto_q,  cnt_alto_d;
    logic [TMO_W-1:0]  timeout_q,   timeout_d;
    logic [LARG_W-1:0] largura_q,   largura_d;
    logic [2:0]        posicao_q,   posicao_d;
    logic              valida_q,    valida_d;
    logic              erro_q,      erro_d;
    logic              sem_sinal_q, sem_sinal_d;
`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
    logic [2:0]        cand_q,      cand_d;
    logic              cand_ok_q,   cand_ok_d;
`endif

    logic [2:0] codigo;
    logic       em_faixa;

    assign codigo   = decodifica(cnt_alto_q);
    assign em_faixa = (cnt_alto_q >= MIN_OK) && (cnt_alto_q <= MAX_OK);

    // State register and all measurement/output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= INICIAL;
            cnt_alto_q  <= '0;
            timeout_q   <= '0;
            largura_q   <= '0;
            posicao_q   <= '0;
            valida_q    <= 1'b0;
            erro_q      <= 1'b0;
            sem_sinal_q <= 1'b0;
`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
            cand_q      <= '0;
            cand_ok_q   <= 1'b0;
`endif
        end else begin
            estado_q    <= estado_d;
            cnt_alto_q  <= cnt_alto_d;
            timeout_q   <= timeout_d;
            largura_q   <= largura_d;
            posicao_q   <= posicao_d;
            valida_q    <= valida_d;
            erro_q      <= erro_d;
            sem_sinal_q <= sem_sinal_d;
`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
            cand_q      <= cand_d;
            cand_ok_q   <= cand_ok_d;
`endif
        end
    end

    // Next-state logic: pulse measurement FSM, classification and timeout tracking.
    always_comb begin
        estado_d   = estado_q;
        cnt_alto_d = cnt_alto_q;
        largura_d  = largura_q;
        posicao_d  = posicao_q;
        valida_d   = 1'b0;
        erro_d     = erro_q;
`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
        cand_d     = cand_q;
        cand_ok_d  = cand_ok_q;
`endif

        // Any rising edge proves the line is alive; otherwise count up to the limit.
        if (subida)
            timeout_d = '0;
        else if (timeout_q != TIMEOUT_V)
            timeout_d = timeout_q + 1'b1;
        else
            timeout_d = timeout_q;
        sem_sinal_d = (timeout_d == TIMEOUT_V);

        unique case (estado_q)
            INICIAL: begin
                // Only start measuring once the line has been seen low.
                if (!nivel)
                    estado_d = ESPERA_SUBIDA;
            end
            ESPERA_SUBIDA: begin
                if (subida) begin
                    estado_d   = MEDE_ALTO;
                    cnt_alto_d = LARG_W'(1);
                end
            end
            MEDE_ALTO: begin
                if (descida)
                    estado_d = CLASSIFICA;
                else if (timeout_q == TIMEOUT_V)
                    estado_d = INICIAL;   // line stuck high: drop the pulse
                else if (cnt_alto_q != CNT_MAX)
                    cnt_alto_d = cnt_alto_q + 1'b1;
            end
            CLASSIFICA: begin
                largura_d = cnt_alto_q;
                estado_d  = ESPERA_SUBIDA;
                if (em_faixa) begin
                    erro_d = 1'b0;
`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
                    if (cand_ok_q && (cand_q == codigo)) begin
                        posicao_d = codigo;
                        valida_d  = 1'b1;
                    end else begin
                        cand_d    = codigo;
                        cand_ok_d = 1'b1;
                    end
`else
                    posicao_d = codigo;
                    valida_d  = 1'b1;
`endif
                end else begin
                    erro_d = 1'b1;
`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
                    cand_ok_d = 1'b0;
`endif
                end
            end
            default: estado_d = INICIAL;
        endcase
    end

    assign posicao        = posicao_q;
    assign posicao_valida = valida_q;
    assign largura_medida = largura_q;
    assign erro           = erro_q;
    assign sem_sinal      = sem_sinal_q;
    assign db_estado      = estado_q;

endmodule

// File: tb/tb_medidor_pwm_servo.sv
// Self-checking bench for medidor_pwm_servo with scaled-down widths so the
// whole run stays short. Expected results come from a behavioural model of
// the decode rules (nearest-midpoint code, tolerance window, sticky error).
module tb_medidor_pwm_servo;

    localparam int unsigned P_PER = 2000;
    localparam int unsigned TMO   = 2 * P_PER;
    localparam int unsigned TOL   = 50;
    localparam int unsigned L0 = 350, L1 = 457, L2 = 564, L3 = 671;
    localparam int unsigned L4 = 778, L5 = 885, L6 = 993, L7 = 1100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm = 1'b0;
    logic [2:0]  posicao;
    logic        posicao_valida;
    logic [16:0] largura_medida;
    logic        erro;
    logic        sem_sinal;
    logic [1:0]  db_estado;

    medidor_pwm_servo #(
        .CONF_PERIODO (P_PER),
        .LARGURA_000  (L0), .LARGURA_001 (L1), .LARGURA_010 (L2), .LARGURA_011 (L3),
        .LARGURA_100  (L4), .LARGURA_101 (L5), .LARGURA_110 (L6), .LARGURA_111 (L7),
        .TOLERANCIA   (TOL),
        .TIMEOUT      (TMO)
    ) dut (
        .clock          (clk),
        .reset          (rst),
        .pwm_in         (pwm),
        .posicao        (posicao),
        .posicao_valida (posicao_valida),
        .largura_medida (largura_medida),
        .erro           (erro),
        .sem_sinal      (sem_sinal),
        .db_estado      (db_estado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int strobes = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (posicao_valida) strobes <= strobes + 1;

    // Reference model state
    int larg [8];
    int exp_pos = 0, exp_erro = 0, exp_larg = 0, exp_strb = 0;
    int cand = 0, cand_ok = 0;
    int last_rise = 0;

    function automatic int dec(input int w);
        int c = 0;
        for (int k = 1; k < 8; k++)
            if (w >= (larg[k-1] + larg[k]) / 2) c++;
        return c;
    endfunction

    task automatic model_pulse(input int w);
        exp_larg = w;
        exp_strb = 0;
        if (w >= larg[0] - int'(TOL) && w <= larg[7] + int'(TOL)) begin
            exp_erro = 0;
`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
            if (cand_ok == 1 && cand == dec(w)) begin
                exp_pos  = dec(w);
                exp_strb = 1;
            end else begin
                cand    = dec(w);
                cand_ok = 1;
            end
`else
            exp_pos  = dec(w);
            exp_strb = 1;
`endif
        end else begin
            exp_erro = 1;
            cand_ok  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input int dstrb);
        chk({tag, ".largura"}, {15'd0, largura_medida}, 32'(exp_larg));
        chk({tag, ".posicao"}, {29'd0, posicao}, 32'(exp_pos));
        chk({tag, ".erro"}, {31'd0, erro}, 32'(exp_erro));
        chk({tag, ".strobes"}, 32'(dstrb), 32'(exp_strb));
    endtask

    task automatic pulse(input string tag, input int w, input int low);
        int s0;
        s0 = strobes;
        @(posedge clk);
        #1 pwm = 1'b1;
        last_rise = cyc;
        repeat (w) @(posedge clk);
        #1 pwm = 1'b0;
        repeat (low) @(posedge clk);
        #2;
        model_pulse(w);
        check_outputs(tag, strobes - s0);
        chk({tag, ".sem_sinal"}, {31'd0, sem_sinal}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".posicao"}, {29'd0, posicao}, 32'd0);
        chk({tag, ".valida"}, {31'd0, posicao_valida}, 32'd0);
        chk({tag, ".largura"}, {15'd0, largura_medida}, 32'd0);
        chk({tag, ".erro"}, {31'd0, erro}, 32'd0);
        chk({tag, ".sem_sinal"}, {31'd0, sem_sinal}, 32'd0);
        chk({tag, ".estado"}, {30'd0, db_estado}, 32'd0);
    endtask

    initial begin
        int s0;
        int mid;
        larg = '{L0, L1, L2, L3, L4, L5, L6, L7};

        // Reset with line idle
        repeat (5) @(posedge clk);
        #2 check_reset_state("reset");
        #1 rst = 1'b0;

        // Nominal code 010, several periods
        for (int i = 0; i < 3; i++) pulse("nominal010", L2, 30);

        // Sweep all nominal widths
        for (int k = 0; k < 8; k++) pulse("sweep", larg[k], 25);

        // Decode thresholds: exactly at the midpoint and one below
        for (int k = 1; k < 8; k++) begin
            mid = (larg[k-1] + larg[k]) / 2;
            pulse("mid_at", mid, 20);
            pulse("mid_below", mid - 1, 20);
        end

        // Tolerance window edges
        pulse("min_ok", L0 - TOL, 20);
        pulse("min_bad", L0 - TOL - 1, 20);
        pulse("max_ok", L7 + TOL, 20);
        pulse("max_bad", L7 + TOL + 1, 20);

        // Out-of-range pulses then recovery
        pulse("nominal011", L3, 20);
        pulse("too_short", 250, 20);
        pulse("too_long", 1200, 20);
        pulse("recover000", L0, 20);

`ifdef MEDIDOR_FILTRO_CONFIRMACAO_EN
        // Confirmation filter: a new code needs two matching pulses
        pulse("filt010a", L2, 20);
        pulse("filt010b", L2, 20);
        pulse("filt101a", L5, 20);
        chk("filt.hold010", {29'd0, posicao}, 32'd2);
        pulse("filt101b", L5, 20);
        chk("filt.take101", {29'd0, posicao}, 32'd5);
`endif

        // Randomized widths, in and out of range
        for (int i = 0; i < 20; i++)
            pulse("random", int'($urandom_range(1300, 200)), int'($urandom_range(40, 10)));

        // Line stuck low: loss of signal after TIMEOUT cycles from the last rise
        while (cyc < last_rise + int'(TMO) - 10) @(posedge clk);
        #2 chk("stuck_low.before", {31'd0, sem_sinal}, 32'd0);
        while (cyc < last_rise + int'(TMO) + 20) @(posedge clk);
        #2;
        chk("stuck_low.after", {31'd0, sem_sinal}, 32'd1);
        chk("stuck_low.posicao", {29'd0, posicao}, 32'(exp_pos));
        chk("stuck_low.estado", {30'd0, db_estado}, 32'd1);
        pulse("after_loss111", L7, 20);

        // Line stuck high: loss of signal, FSM back to INICIAL, pulse discarded
        s0 = strobes;
        @(posedge clk);
        #1 pwm = 1'b1;
        last_rise = cyc;
        while (cyc < last_rise + int'(TMO) + 50) @(posedge clk);
        #2;
        chk("stuck_high.sem_sinal", {31'd0, sem_sinal}, 32'd1);
        chk("stuck_high.estado", {30'd0, db_estado}, 32'd0);
        #1 pwm = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check_outputs("stuck_high", strobes - s0 + exp_strb);
        chk("stuck_high.sem_hold", {31'd0, sem_sinal}, 32'd1);
        pulse("after_high011", L3, 20);

        // Reset in the middle of a pulse
        s0 = strobes;
        @(posedge clk);
        #1 pwm = 1'b1;
        repeat (400) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_state("mid_reset");
        exp_pos = 0; exp_erro = 0; exp_larg = 0; cand_ok = 0;
        repeat (400) @(posedge clk);
        #1 pwm = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("mid_reset.strobes", 32'(strobes - s0), 32'd0);
        chk("mid_reset.largura", {15'd0, largura_medida}, 32'd0);
        chk("mid_reset.posicao", {29'd0, posicao}, 32'd0);
        pulse("after_reset101", L5, 20);
        pulse("after_reset101b", L5, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
